// File: rtl/tl_buffer_pkg.sv
// tl_buffer_pkg: TileLink channel field widths and packed beat types shared by the buffer.
package tl_buffer_pkg;
    localparam int OPCODE_W = 3;
    localparam int A_PARAM_W = 3;
    localparam int D_PARAM_W = 2;
    localparam int SIZE_W = 3;
    localparam int SOURCE_W = 4;
    localparam int SINK_W = 3;
    localparam int ADDR_W = 32;
    localparam int MASK_W = 8;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [A_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SOURCE_W-1:0]  source;
        logic [ADDR_W-1:0]    address;
        logic [MASK_W-1:0]    mask;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } tl_a_beat_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [D_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SOURCE_W-1:0]  source;
        logic [SINK_W-1:0]    sink;
        logic                 denied;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } tl_d_beat_t;
endpackage

// File: rtl/tl_buffer_ad_queue.sv
// tl_queue: registered FIFO; ready is !full and valid is !empty, with no pipe or flow-through path.
module tl_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic maybe_full, ptr_match, enq_fire, deq_fire;
    assign ptr_match = wr_ptr == rd_ptr;
    assign enq_ready = !(ptr_match && maybe_full);
    assign deq_valid = !(ptr_match && !maybe_full);
    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;
    assign deq_bits = ram[rd_ptr];
    // Storage is deliberately left out of reset; only the pointers define occupancy.
    always_ff @(posedge clock)
        if (enq_fire) ram[wr_ptr] <= enq_bits;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + AW'(1);
            if (enq_fire != deq_fire) maybe_full <= enq_fire;
        end
    end
endmodule

// File: rtl/tl_buffer_ad.sv
// tl_buffer_ad: TileLink buffer queueing the A and D channels; C and E pass straight through.
module tl_buffer_ad
    import tl_buffer_pkg::*;
#(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 auto_in_a_valid,
    output logic                 auto_in_a_ready,
    input  logic [OPCODE_W-1:0]  auto_in_a_bits_opcode,
    input  logic [A_PARAM_W-1:0] auto_in_a_bits_param,
    input  logic [SIZE_W-1:0]    auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0]  auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]    auto_in_a_bits_address,
    input  logic [MASK_W-1:0]    auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]    auto_in_a_bits_data,
    input  logic                 auto_in_a_bits_corrupt,
    output logic                 auto_out_a_valid,
    input  logic                 auto_out_a_ready,
    output logic [OPCODE_W-1:0]  auto_out_a_bits_opcode,
    output logic [A_PARAM_W-1:0] auto_out_a_bits_param,
    output logic [SIZE_W-1:0]    auto_out_a_bits_size,
    output logic [SOURCE_W-1:0]  auto_out_a_bits_source,
    output logic [ADDR_W-1:0]    auto_out_a_bits_address,
    output logic [MASK_W-1:0]    auto_out_a_bits_mask,
    output logic [DATA_W-1:0]    auto_out_a_bits_data,
    output logic                 auto_out_a_bits_corrupt,
    input  logic                 auto_out_d_valid,
    output logic                 auto_out_d_ready,
    input  logic [OPCODE_W-1:0]  auto_out_d_bits_opcode,
    input  logic [D_PARAM_W-1:0] auto_out_d_bits_param,
    input  logic [SIZE_W-1:0]    auto_out_d_bits_size,
    input  logic [SOURCE_W-1:0]  auto_out_d_bits_source,
    input  logic [SINK_W-1:0]    auto_out_d_bits_sink,
    input  logic                 auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]    auto_out_d_bits_data,
    input  logic                 auto_out_d_bits_corrupt,
    output logic                 auto_in_d_valid,
    input  logic                 auto_in_d_ready,
    output logic [OPCODE_W-1:0]  auto_in_d_bits_opcode,
    output logic [D_PARAM_W-1:0] auto_in_d_bits_param,
    output logic [SIZE_W-1:0]    auto_in_d_bits_size,
    output logic [SOURCE_W-1:0]  auto_in_d_bits_source,
    output logic [SINK_W-1:0]    auto_in_d_bits_sink,
    output logic                 auto_in_d_bits_denied,
    output logic [DATA_W-1:0]    auto_in_d_bits_data,
    output logic                 auto_in_d_bits_corrupt,
    input  logic                 auto_in_c_valid,
    output logic                 auto_in_c_ready,
    input  logic [OPCODE_W-1:0]  auto_in_c_bits_opcode,
    input  logic [A_PARAM_W-1:0] auto_in_c_bits_param,
    input  logic [SIZE_W-1:0]    auto_in_c_bits_size,
    input  logic [SOURCE_W-1:0]  auto_in_c_bits_source,
    input  logic [ADDR_W-1:0]    auto_in_c_bits_address,
    input  logic [DATA_W-1:0]    auto_in_c_bits_data,
    input  logic                 auto_in_c_bits_corrupt,
    output logic                 auto_out_c_valid,
    input  logic                 auto_out_c_ready,
    output logic [OPCODE_W-1:0]  auto_out_c_bits_opcode,
    output logic [A_PARAM_W-1:0] auto_out_c_bits_param,
    output logic [SIZE_W-1:0]    auto_out_c_bits_size,
    output logic [SOURCE_W-1:0]  auto_out_c_bits_source,
    output logic [ADDR_W-1:0]    auto_out_c_bits_address,
    output logic [DATA_W-1:0]    auto_out_c_bits_data,
    output logic                 auto_out_c_bits_corrupt,
    input  logic                 auto_in_e_valid,
    input  logic [SINK_W-1:0]    auto_in_e_bits_sink,
    output logic                 auto_out_e_valid,
    output logic [SINK_W-1:0]    auto_out_e_bits_sink
);
    tl_a_beat_t a_enq, a_deq;
    tl_d_beat_t d_enq, d_deq;
    assign a_enq = '{auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                     auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                     auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign d_enq = '{auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                     auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                     auto_out_d_bits_data, auto_out_d_bits_corrupt};

    tl_queue #(.WIDTH($bits(tl_a_beat_t)), .DEPTH(A_DEPTH)) a_q (
        .clock(clock), .reset(reset),
        .enq_valid(auto_in_a_valid), .enq_ready(auto_in_a_ready), .enq_bits(a_enq),
        .deq_valid(auto_out_a_valid), .deq_ready(auto_out_a_ready), .deq_bits(a_deq)
    );

    tl_queue #(.WIDTH($bits(tl_d_beat_t)), .DEPTH(D_DEPTH)) d_q (
        .clock(clock), .reset(reset),
        .enq_valid(auto_out_d_valid), .enq_ready(auto_out_d_ready), .enq_bits(d_enq),
        .deq_valid(auto_in_d_valid), .deq_ready(auto_in_d_ready), .deq_bits(d_deq)
    );

    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq;
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq;

    // Release and grant-ack traffic is never buffered, so it is unaffected by reset.
    assign auto_out_c_valid        = auto_in_c_valid;
    assign auto_in_c_ready         = auto_out_c_ready;
    assign auto_out_c_bits_opcode  = auto_in_c_bits_opcode;
    assign auto_out_c_bits_param   = auto_in_c_bits_param;
    assign auto_out_c_bits_size    = auto_in_c_bits_size;
    assign auto_out_c_bits_source  = auto_in_c_bits_source;
    assign auto_out_c_bits_address = auto_in_c_bits_address;
    assign auto_out_c_bits_data    = auto_in_c_bits_data;
    assign auto_out_c_bits_corrupt = auto_in_c_bits_corrupt;
    assign auto_out_e_valid        = auto_in_e_valid;
    assign auto_out_e_bits_sink    = auto_in_e_bits_sink;
endmodule
